// File: rtl/zld_xc4_dec_if.sv
// Token-in / symbol-out stream bundle for the zero run-length decoder.
// With ZLD_EOS_EN defined the bundle also carries the end-of-stream flags.
interface zld_xc4_dec_if;
  logic [4:0] i_d;
  logic       i_valid;
  logic       i_ready;
  logic [2:0] o_d;
  logic       o_valid;
  logic       o_ready;
`ifdef ZLD_EOS_EN
  logic       i_eos;
  logic       o_eos;

  modport master (output i_d, i_valid, i_eos, o_ready,
                  input  i_ready, o_d, o_valid, o_eos);
  modport slave  (input  i_d, i_valid, i_eos, o_ready,
                  output i_ready, o_d, o_valid, o_eos);
`else
  modport master (output i_d, i_valid, o_ready,
                  input  i_ready, o_d, o_valid);
  modport slave  (input  i_d, i_valid, o_ready,
                  output i_ready, o_d, o_valid);
`endif
endinterface

// File: rtl/zld_xc4_dec.sv
// Zero run-length decoder: expands 5-bit literal/run tokens into 3-bit symbols.
// Optional end-of-stream marker pass-through is enabled by defining ZLD_EOS_EN.
//
// state | meaning
// EMPTY | output register holds nothing, rem = 0
// HOLD  | o_d holds a symbol, no zeros owed after it
// RUN   | o_d holds a zero, rem more zeros owed after it
module zld_xc4_dec (
  input logic           clock,
  input logic           reset,
  zld_xc4_dec_if.slave  bus
);
  typedef enum logic [1:0] {EMPTY = 2'd0, HOLD = 2'd1, RUN = 2'd2} state_t;

  state_t     state_q, state_d;
  logic [2:0] o_d_q, o_d_d;
  logic [3:0] rem_q, rem_d;
  logic       o_vld;
  logic       in_rdy;
  logic       in_acc;
  logic       out_xfer;
`ifdef ZLD_EOS_EN
  logic       eos_q, eos_d;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      o_d_q   <= 3'd0;
      rem_q   <= 4'd0;
`ifdef ZLD_EOS_EN
      eos_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      o_d_q   <= o_d_d;
      rem_q   <= rem_d;
`ifdef ZLD_EOS_EN
      eos_q   <= eos_d;
`endif
    end
  end

  // Accept only when no zeros are owed, so RUN never sees an input load.
  always_comb begin
    state_d = state_q;
    o_d_d   = o_d_q;
    rem_d   = rem_q;
`ifdef ZLD_EOS_EN
    eos_d   = eos_q;
`endif
    in_acc   = bus.i_valid && in_rdy;
    out_xfer = o_vld && bus.o_ready;
    if (in_acc) begin
`ifdef ZLD_EOS_EN
      eos_d = bus.i_eos;
      if (bus.i_eos) begin
        o_d_d   = 3'd0;
        rem_d   = 4'd0;
        state_d = HOLD;
      end else
`endif
      if (bus.i_d[4]) begin
        o_d_d   = 3'd0;
        rem_d   = bus.i_d[3:0];
        state_d = (bus.i_d[3:0] == 4'd0) ? HOLD : RUN;
      end else begin
        o_d_d   = bus.i_d[2:0];
        rem_d   = 4'd0;
        state_d = HOLD;
      end
    end else if (out_xfer) begin
      if (state_q == RUN) begin
        rem_d   = rem_q - 4'd1;
        state_d = (rem_q == 4'd1) ? HOLD : RUN;
      end else begin
        o_d_d   = 3'd0;
        state_d = EMPTY;
`ifdef ZLD_EOS_EN
        eos_d   = 1'b0;
`endif
      end
    end
  end

  always_comb begin
    o_vld       = (state_q != EMPTY);
    in_rdy      = (rem_q == 4'd0) && (!o_vld || bus.o_ready);
    bus.o_valid = o_vld;
    bus.o_d     = o_d_q;
    bus.i_ready = in_rdy;
`ifdef ZLD_EOS_EN
    bus.o_eos   = eos_q;
`endif
  end
endmodule

// File: tb/tb_zld_xc4_dec.sv
// Scoreboard bench for zld_xc4_dec: directed tokens, expected symbols queued,
// monitor pops on every output transfer. Covers ZLD_EOS_EN when defined.
module tb_zld_xc4_dec;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   xfers  = 0;
  logic [3:0] exp_q[$];

  zld_xc4_dec_if bus();

  zld_xc4_dec dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: every output transfer must match the head of the queue.
  always @(negedge clock) begin
    logic [3:0] act;
    logic [3:0] e;
    if (reset && bus.o_valid && bus.o_ready) begin
      xfers++;
`ifdef ZLD_EOS_EN
      act = {bus.o_eos, bus.o_d};
`else
      act = {1'b0, bus.o_d};
`endif
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected actual=%0h required=none", act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL sb_symbol actual=%0h required=%0h", act, e);
        end
      end
    end
  end

  task automatic push_zeros(input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(4'h0);
  endtask

  task automatic send(input logic [4:0] tok, input logic eos, output int waits);
    int  n;
    bit  acc;
    n   = 0;
    acc = 0;
    bus.i_d     = tok;
    bus.i_valid = 1'b1;
`ifdef ZLD_EOS_EN
    bus.i_eos   = eos;
`else
    if (eos) $display("eos token ignored in this build");
`endif
    while (!acc && n < 200) begin
      @(negedge clock);
      if (bus.i_ready) acc = 1;
      else n++;
      @(posedge clock);
      #1;
    end
    bus.i_valid = 1'b0;
`ifdef ZLD_EOS_EN
    bus.i_eos   = 1'b0;
`endif
    if (!acc) chk("send_timeout", 0, 1);
    waits = n;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (bus.o_valid && n < 100) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (bus.o_valid) chk("drain_timeout", 1, 0);
  endtask

  initial begin
    int w0, w1, w2, base, n;
    logic pat [5];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    bus.i_d     = 5'd0;
    bus.i_valid = 1'b0;
    bus.o_ready = 1'b1;
`ifdef ZLD_EOS_EN
    bus.i_eos   = 1'b0;
`endif
    repeat (2) @(posedge clock);
    #1;
    chk("rst_o_valid", int'(bus.o_valid), 0);
    chk("rst_o_d", int'(bus.o_d), 0);
    chk("rst_i_ready", int'(bus.i_ready), 1);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // back-to-back literals
    exp_q.push_back(4'h5); exp_q.push_back(4'h2); exp_q.push_back(4'h7);
    base = xfers;
    send(5'h05, 1'b0, w0);
    send(5'h02, 1'b0, w1);
    send(5'h07, 1'b0, w2);
    chk("lit_wait0", w0, 0);
    chk("lit_wait1", w1, 0);
    chk("lit_wait2", w2, 0);
    chk("lit_consecutive", xfers - base, 2);
    chk("lit_last_o_d", int'(bus.o_d), 7);

    // run of 4 then literal with no gap
    push_zeros(4); exp_q.push_back(4'h1);
    send(5'h13, 1'b0, w0);
    send(5'h01, 1'b0, w1);
    chk("run4_wait_first", w0, 0);
    chk("run4_ready_low", w1, 3);
    drain();

    // run of 16, then run of 1, then literal
    push_zeros(16); push_zeros(1); exp_q.push_back(4'h4);
    base = xfers;
    send(5'h1F, 1'b0, w0);
    send(5'h10, 1'b0, w1);
    send(5'h04, 1'b0, w2);
    chk("run16_ready_low", w1, 15);
    chk("run1_ready_low", w2, 0);
    drain();
    chk("run16_run1_count", xfers - base, 18);

    // run of 3 under o_ready toggling
    push_zeros(3);
    base = xfers;
    send(5'h12, 1'b0, w0);
    for (int k = 0; k < 5; k++) begin
      bus.o_ready = pat[k];
      @(posedge clock);
      #1;
    end
    bus.o_ready = 1'b1;
    chk("bp_count", xfers - base, 3);
    chk("bp_o_valid_after", int'(bus.o_valid), 0);

    // reset mid-run after 5 zeros
    push_zeros(16);
    base = xfers;
    send(5'h1F, 1'b0, w0);
    n = 0;
    while ((xfers - base) < 5 && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("mid_reset_zeros_seen", xfers - base, 5);
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk("mid_reset_o_valid", int'(bus.o_valid), 0);
    chk("mid_reset_i_ready", int'(bus.i_ready), 1);
    exp_q.delete();
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("post_reset_empty", int'(bus.o_valid), 0);
    exp_q.push_back(4'h3);
    base = xfers;
    send(5'h03, 1'b0, w0);
    drain();
    chk("post_reset_count", xfers - base, 1);

`ifdef ZLD_EOS_EN
    push_zeros(2); exp_q.push_back(4'h8);
    base = xfers;
    send(5'h11, 1'b0, w0);
    send(5'h00, 1'b1, w1);
    chk("eos_wait", w1, 1);
    drain();
    chk("eos_count", xfers - base, 3);
    chk("eos_o_valid_after", int'(bus.o_valid), 0);
`endif

    repeat (2) @(posedge clock);
    #1;
    chk("sb_empty", exp_q.size(), 0);
    chk("end_o_valid", int'(bus.o_valid), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/zld_xc4_dec.md
# zld_xc4_dec

Zero run-length decoder: the stage directly downstream of the ZLE encoder datapath. It consumes 5-bit encoder tokens, each either a 3-bit literal or a zero-run code. It expands them back into the original 3-bit symbol stream, one symbol per cycle, with valid/ready flow control on both sides. A single output register and a run counter make it fully pipelined: one literal per cycle, one zero per cycle during runs.

## Interface
- No parameters. Widths are fixed to match the encoder: 3-bit symbols, 4-bit run field.
- clock  in  1  single clock; all state on posedge.
- reset  in  1  asynchronous, active-low (`!reset` clears all state immediately).
- i_d  in  5  input token. Bit 4 = 1: zero run of `i_d[3:0]+1` zeros (1..16). Bit 4 = 0: literal `i_d[2:0]`, with `i_d[3]` ignored.
- i_valid  in  1  token on i_d is valid.
- i_ready  out  1  decoder accepts the token this cycle; transfer happens when `i_valid && i_ready`.
- o_d  out  3  decoded symbol.
- o_valid  out  1  o_d holds a symbol.
- o_ready  in  1  consumer takes the symbol; transfer happens when `o_valid && o_ready`.
- i_eos, o_eos  in/out  1  end-of-stream flag. Present only with ZLD_EOS_EN (see Configuration).

## Operation
- State:
  - output register `{o_valid, o_d}`.
  - `rem[3:0]`: zeros still owed after the one currently in o_d.
- FSM, derived from state:
  - EMPTY: `o_valid=0`, `rem=0`.
  - HOLD: `o_valid=1`, `rem=0`.
  - RUN: `o_valid=1`, `rem!=0`.
- `i_ready = (rem==0) && (!o_valid || o_ready)`. This is combinational, with no combinational path from i_valid to i_ready.
- Accept a literal (`i_d[4]=0`):
  - `o_d <= i_d[2:0]`, `o_valid <= 1`.
  - Next state is HOLD.
- Accept a run (`i_d[4]=1`):
  - `o_d <= 0`, `o_valid <= 1`, `rem <= i_d[3:0]`.
  - Next state is RUN, or HOLD if `i_d[3:0]=0`.
- RUN with output transfer:
  - o_d stays 0, o_valid stays 1, `rem <= rem-1`.
  - When rem reaches 0 the state becomes HOLD.
  - rem never wraps, because it is only decremented when nonzero.
- HOLD with output transfer and no input accept: `o_valid <= 0`, next state EMPTY.
- HOLD with output transfer and simultaneous input accept: the new token loads directly. There is no bubble.
- Output held without transfer (`o_ready=0`): o_d, o_valid and rem are all frozen, i_ready=0, and any input token waits.
- o_d is don't-care when o_valid=0; the implementation drives 0.

## Timing
- Reset values: `o_valid=0`, `o_d=0`, `rem=0`, hence `i_ready=1`. eos register is 0.
- Latency: a token accepted in cycle t produces its first symbol with o_valid=1 in cycle t+1.
- Throughput:
  - One literal per cycle with `o_ready=1` continuously.
  - A run of N zeros occupies N consecutive output cycles. i_ready is low for the first N-1 of those cycles and rises in the cycle the last zero is presented, so the next token loads with no gap.
- Backpressure: deasserting o_ready stalls the decoder in place for any number of cycles without loss or duplication.
- Reset mid-run: all pending zeros and the held symbol are discarded. The block is in EMPTY on the first clock after reset deasserts.

## Configuration
- ZLD_EOS_EN defined:
  - Adds ports `i_eos` and `o_eos`.
  - An accepted token with `i_eos=1` is an end-of-stream marker; its i_d is ignored.
  - It is accepted only under the normal i_ready rule, so any pending run is always drained first.
  - It loads the output with `o_d=0`, `o_eos=1`, `o_valid=1` (HOLD).
  - When that output transfers, the block returns to EMPTY.
  - o_eos is 0 for every data symbol.
- ZLD_EOS_EN undefined: ports i_eos and o_eos are absent, there is no eos register, and every token is data.

## Test plan
- After reset with `o_ready=1`, tokens 0x05, 0x02, 0x07 back-to-back → o_d = 5, 2, 7 on three consecutive cycles starting one cycle after the first accept. i_ready stays 1 throughout.
- Token 0x13 (run of 4) then literal 0x01 with `o_ready=1` → o_d = 0, 0, 0, 0, 1 on consecutive cycles. i_ready is low exactly 3 cycles.
- Token 0x1F (run of 16) → exactly 16 zeros, no wrap. Token 0x10 → exactly 1 zero, and i_ready is never deasserted.
- Run 0x12 with o_ready toggling 1,0,0,1,1 → exactly 3 zeros are delivered, only on o_ready=1 cycles. No drop and no duplicate.
- Reset asserted mid-run (0x1F, after 5 zeros) → o_valid=0 and i_ready=1 immediately. A following literal 0x03 produces only one output, 3.
- ZLD_EOS_EN: run 0x11 then eos token → output sequence is 0, 0, then `o_eos=1` with `o_d=0`. After that transfer, o_valid=0.
